// File: rtl/spike_delay_buffer_pkg.sv
// snn_pkg: shared constants and helpers for the spiking-network datapath blocks.
package snn_pkg;
    localparam int DELAY_BITS = 3;
    localparam int ACT_CNT_W  = 8;

    function automatic int MAX_DELAY(input int delay_bits);
        return (1 << delay_bits) - 1;
    endfunction
endpackage

// File: rtl/spike_delay_buffer_if.sv
// spike_delay_buffer_if: step strobe, spike and delay inputs, delayed spikes and activity count.
interface spike_delay_buffer_if #(
    parameter int M          = 8,
    parameter int DELAY_BITS = snn_pkg::DELAY_BITS
);
    import snn_pkg::*;
    logic                    enable;
    logic                    clear;
    logic [M-1:0]            input_spikes;
    logic [M*DELAY_BITS-1:0] delays;
    logic [M-1:0]            delayed_spikes;
    logic [ACT_CNT_W-1:0]    activity_count;

    modport master (
        output enable, clear, input_spikes, delays,
        input  delayed_spikes, activity_count
    );
    modport slave (
        input  enable, clear, input_spikes, delays,
        output delayed_spikes, activity_count
    );
endinterface

// File: rtl/spike_delay_buffer_channel.sv
// spike_delay_channel: one spike line's history shift register with a programmable tap.
module spike_delay_channel #(
    parameter int DELAY_BITS = snn_pkg::DELAY_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  spike_in,
    input  logic [DELAY_BITS-1:0] delay,
    output logic                  spike_out
);
    import snn_pkg::*;
    localparam int D = MAX_DELAY(DELAY_BITS);

    logic [D-1:0] r_hist;
    logic         r_spike;
    logic [D:0]   w_taps;

    // tap 0 is the live input, tap k is hist[k-1]
    assign w_taps    = {r_hist, spike_in};
    assign spike_out = r_spike;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_hist  <= '0;
            r_spike <= 1'b0;
        end else if (enable) begin
            r_hist  <= w_taps[D-1:0];
            r_spike <= w_taps[delay];
        end
    end
endmodule

// File: rtl/spike_delay_buffer.sv
// spike_delay_buffer: per-channel programmable axonal delay ahead of the LIF neuron.
module spike_delay_buffer #(
    parameter int M          = 8,
    parameter int DELAY_BITS = snn_pkg::DELAY_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    spike_delay_buffer_if.slave  bus
);
    import snn_pkg::*;

    logic [M-1:0]         w_spikes;
    logic [ACT_CNT_W-1:0] r_cnt;

    for (genvar g = 0; g < M; g++) begin : g_ch
        spike_delay_channel #(.DELAY_BITS(DELAY_BITS)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .enable    (bus.enable),
            .clear     (bus.clear),
            .spike_in  (bus.input_spikes[g]),
            .delay     (bus.delays[g*DELAY_BITS +: DELAY_BITS]),
            .spike_out (w_spikes[g])
        );
    end

    // r_cnt excludes the step now on the outputs; adding it here keeps the count on the same edge
    assign bus.delayed_spikes = w_spikes;
    assign bus.activity_count = (&r_cnt) ? r_cnt : r_cnt + ACT_CNT_W'(|w_spikes);

    always_ff @(posedge clk) begin
        if (reset || bus.clear)
            r_cnt <= '0;
        else if (bus.enable)
            r_cnt <= bus.activity_count;
    end
endmodule

// File: tb/tb_spike_delay_buffer.sv
// tb_spike_delay_buffer: vector table, corner-case sequences and a scoreboarded random run.
module tb_spike_delay_buffer;
    import snn_pkg::*;
    localparam int M  = 8;
    localparam int DB = 3;

    typedef struct {
        logic       en;
        logic       cl;
        logic [7:0] in;
        logic [7:0] out;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        logic [7:0] o;
        logic [7:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spike_delay_buffer_if #(.M(M), .DELAY_BITS(DB)) bus ();
    spike_delay_buffer #(.M(M), .DELAY_BITS(DB)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    vec_t tbl[8];
    exp_t sb[$];
    logic [7:0] past[$];
    logic [23:0] dl;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rs, input logic en, input logic cl, input logic [7:0] in);
        reset = rs;
        bus.enable = en;
        bus.clear = cl;
        bus.input_spikes = in;
        bus.delays = dl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
    endtask

    initial begin
        logic en_pat[6];
        exp_t e, last, got;
        logic en, cl;
        logic [7:0] in, eo;
        int d;
        en_pat = '{1, 0, 0, 1, 0, 1};
        tbl[0] = '{1, 0, 8'hA5, 8'hA5, 8'd1};
        tbl[1] = '{1, 0, 8'h00, 8'h00, 8'd1};
        tbl[2] = '{0, 0, 8'hFF, 8'h00, 8'd1};
        tbl[3] = '{1, 0, 8'h3C, 8'h3C, 8'd2};
        tbl[4] = '{0, 0, 8'h00, 8'h3C, 8'd2};
        tbl[5] = '{1, 0, 8'h00, 8'h00, 8'd2};
        tbl[6] = '{1, 1, 8'hFF, 8'h00, 8'd0};
        tbl[7] = '{1, 0, 8'h01, 8'h01, 8'd1};
        dl = '0;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.clear = 1'b0;
        bus.input_spikes = '0;
        bus.delays = '0;
        do_reset();
        check("reset_out", bus.delayed_spikes, 8'h00);
        check("reset_cnt", bus.activity_count, 8'h00);

        for (int k = 0; k < 8; k++) begin
            step(0, tbl[k].en, tbl[k].cl, tbl[k].in);
            check($sformatf("tbl%0d_out", k), bus.delayed_spikes, tbl[k].out);
            check($sformatf("tbl%0d_cnt", k), bus.activity_count, tbl[k].cnt);
        end

        dl = 24'd5 << 9;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0, k == 0 ? 8'h08 : 8'h00);
            check($sformatf("ch3_d5_step%0d", k), bus.delayed_spikes, k == 5 ? 8'h08 : 8'h00);
        end

        dl = 24'd2;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(0, en_pat[k], 0, k == 0 ? 8'h01 : 8'h00);
            check($sformatf("ch0_gap_cyc%0d", k), bus.delayed_spikes, k == 5 ? 8'h01 : 8'h00);
        end
        step(0, 0, 0, 8'h00);
        check("ch0_gap_hold", bus.delayed_spikes, 8'h01);
        check("ch0_gap_cnt", bus.activity_count, 8'd1);

        dl = '1;
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            step(0, 1, 0, 8'hFF);
            if (k <= 8)
                check($sformatf("max_d_step%0d", k), bus.delayed_spikes, k == 8 ? 8'hFF : 8'h00);
            if (k == 8)
                check("max_d_cnt1", bus.activity_count, 8'd1);
        end
        check("sat_cnt", bus.activity_count, 8'd255);
        step(0, 1, 0, 8'hFF);
        check("sat_hold", bus.activity_count, 8'd255);

        dl = {8{3'd4}};
        do_reset();
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'hFF);
        step(0, 1, 1, 8'hFF);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0, 8'h00);
            check($sformatf("clr_flight_out%0d", k), bus.delayed_spikes, 8'h00);
        end
        check("clr_flight_cnt", bus.activity_count, 8'd0);

        dl = {8{3'd1}};
        do_reset();
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'hFF);
        check("rc_pre_out", bus.delayed_spikes, 8'hFF);
        step(1, 1, 1, 8'hFF);
        check("rc_out", bus.delayed_spikes, 8'h00);
        check("rc_cnt", bus.activity_count, 8'd0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 8'h00);
            check($sformatf("rc_after%0d", k), bus.delayed_spikes, 8'h00);
        end

        dl = 24'($urandom);
        do_reset();
        last = '{8'h00, 8'h00};
        for (int k = 0; k < 120; k++) begin
            en = $urandom_range(0, 9) < 7;
            cl = $urandom_range(0, 19) == 0;
            in = 8'($urandom);
            if ($urandom_range(0, 9) == 0) dl = 24'($urandom);
            if (cl) begin
                e = '{8'h00, 8'h00};
                past.delete();
            end else if (en) begin
                for (int i = 0; i < M; i++) begin
                    d = int'(dl[i*DB +: DB]);
                    eo[i] = (d == 0) ? in[i] : (d <= past.size() ? past[d-1][i] : 1'b0);
                end
                past.push_front(in);
                if (past.size() > 7) void'(past.pop_back());
                e.o = eo;
                e.c = (eo != 0 && last.c != 8'd255) ? last.c + 8'd1 : last.c;
            end else begin
                e = last;
            end
            sb.push_back(e);
            last = e;
            step(0, en, cl, in);
            got = sb.pop_front();
            check($sformatf("rnd%0d_out", k), bus.delayed_spikes, got.o);
            check($sformatf("rnd%0d_cnt", k), bus.activity_count, got.c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spike_delay_buffer.md
# spike_delay_buffer

Per-synapse programmable axonal delay stage, placed directly upstream of `LIF_Neuron_debug`. It delays each of M incoming spike lines by its own configurable number of time steps. Its `delayed_spikes` output drives the neuron's `input_spikes` port. Time advances only on cycles where `enable` is high, so the buffer and the neuron step in lockstep.

## Interface
- `M`, 8: number of spike channels; equals the downstream neuron's M.
- `DELAY_BITS`, 3: width of each per-channel delay field. Maximum delay is 2^DELAY_BITS − 1 steps.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: time-step strobe. State advances only when high.
- `clear` input 1: synchronous flush of spike history, outputs and count.
- `input_spikes` input M: raw spikes for the current step.
- `delays` input M*DELAY_BITS: channel i delay is `delays[i*DELAY_BITS +: DELAY_BITS]`.
- `delayed_spikes` output M: registered delayed spikes; connect to the neuron's `input_spikes`.
- `activity_count` output 8: saturating count of enabled steps with at least one delayed spike emitted.

## Operation
- Each channel i holds a history shift register `hist_i[0..D-1]`, where D = 2^DELAY_BITS − 1.
- On an enabled cycle, without reset or clear, all of the following happen in the same edge:
  - `hist_i[0] <= input_spikes[i]`.
  - `hist_i[k] <= hist_i[k-1]` for k = 1..D−1.
  - `delayed_spikes[i] <= (d_i == 0) ? input_spikes[i] : hist_i[d_i − 1]`, where d_i is the channel's current delay.
  - If the new `delayed_spikes` vector is nonzero, `activity_count` increments by 1, saturating at 255.
- On a cycle with `enable` low, history, `delayed_spikes` and `activity_count` all hold.
- The delay mux uses the value of `delays` sampled at the enabled edge, and history is not cleared. Changing a delay mid-stream therefore retargets the tap immediately: spikes can be duplicated or skipped, and this is accepted behaviour.
- `clear` zeroes all history, `delayed_spikes` and `activity_count`, whether or not `enable` is high. The `input_spikes` presented on that cycle are discarded.
- `reset` has the same effect as `clear`. When both are high, reset takes precedence and the result is identical.
- Channels are fully independent; there is no cross-channel arithmetic.

## Timing
- Reset values: `delayed_spikes` = 0, `activity_count` = 0, all history = 0.
- Latency: a spike on channel i at enabled step t appears on `delayed_spikes[i]` after the edge of enabled step t + d_i.
  - Seen by the neuron at step t + d_i + 1, i.e. d_i + 1 enabled edges after it was sampled.
  - For d_i = 0 that is a 1-step registered pass-through.
- Gaps in `enable` stretch latency in clock cycles; latency in enabled steps is unchanged.
- Maximum delay is D: the tap at `hist_i[D-1]`. No saturation logic is needed because the field cannot exceed D.
- `activity_count` updates on the same edge as `delayed_spikes`, and at 255 it stays at 255.
- Reset or clear asserted mid-stream drops every in-flight spike. The first new spike can appear no earlier than d_i + 1 enabled steps after reset or clear deasserts.

## Structure
- Shared package `snn_pkg` holds the default `DELAY_BITS`, a `MAX_DELAY` function (2^DELAY_BITS − 1) and the `ACT_CNT_W` = 8 constant.
- Sub-module `spike_delay_channel`, instantiated M times via generate:
  - Contains one D-bit history register and the tap mux.
  - Has its own registered output bit.
  - Has ports clk, reset, enable, clear, spike_in, delay, spike_out.
- The top level holds the generate loop, delay-field slicing and the activity counter.

## Test plan
- Reset, then M=8, all delays 0, `input_spikes`=8'hA5 for one enabled cycle → `delayed_spikes`=8'hA5 after that edge, 8'h00 the next step; `activity_count`=1.
- Channel 3 delay 5, a single spike at step 0 with enable held high → `delayed_spikes[3]` high only after the edge of step 5; other bits stay 0.
- Channel 0 delay 2, `enable` pattern 1,0,0,1,0,1 with a spike at the first enabled cycle → output rises after the third enabled edge (clock cycle 6); it holds through low-enable cycles.
- Delay 7 (maximum), continuous spikes on all channels → output goes all-ones after the 8th enabled edge; after 300 steps `activity_count` saturates at 255.
- Spikes in flight with delay 4, then `clear` pulsed at step 2 together with `enable` → no output spike ever emerges from the pre-clear inputs; count = 0.
- `reset` and `clear` both high with `enable` high and `input_spikes`=8'hFF → all outputs 0 on the next cycle, and that input is never emitted.
